downcounter_mmss_timer: RTL and testbench
=========================================

Name: downcounter_mmss_timer

Overview:
- Four-digit BCD countdown timer, MM:SS format.
- Complements the cascaded BCD up-counters: it counts down with a borrow chain instead of a carry chain.
- Loaded from switches, decremented by an external 1 Hz enable tick, and drives the 7-segment display path.
- Signals completion through a level flag and a one-cycle pulse for the buzzer/LED logic.

Parameters:
- BCD_BIT_WIDTH, 4, width of each BCD digit.
- SEC_TENS_LIMIT, 5, maximum value of the seconds tens digit (val1).
- MIN_TENS_LIMIT, 5, maximum value of the minutes tens digit (val3).

Ports:
- clk  input  1  system clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- decrease  input  1  one-cycle enable tick (1 Hz); requests one decrement.
- start_pause  input  1  one-cycle pulse (already debounced); toggles run/pause.
- load  input  1  one-cycle pulse; loads load_val0..3.
- load_val0..load_val3  input  BCD_BIT_WIDTH each  preset digits (sec ones, sec tens, min ones, min tens).
- val0..val3  output  BCD_BIT_WIDTH each  current digits (sec ones, sec tens, min ones, min tens).
- running  output  1  high while in RUN.
- done  output  1  high while in DONE.
- done_pulse  output  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset (async, rst_n=0): val0..val3=0, state=IDLE, running=0, done=0, done_pulse=0. Takes effect immediately, including mid-count.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Input priority within one cycle: load > start_pause > decrease.
- Load (any state):
  - Digits are captured on the next edge and state goes to IDLE.
  - Out-of-range digits are clamped: val0/val2 > 9 -> 9; val1 > SEC_TENS_LIMIT -> SEC_TENS_LIMIT; val3 > MIN_TENS_LIMIT -> MIN_TENS_LIMIT.
- IDLE:
  - start_pause with a nonzero value -> RUN.
  - start_pause with value 00:00 is ignored.
  - decrease is ignored.
- RUN:
  - decrease decrements by one second.
  - Borrow chain: val0 0 -> 9 borrows from val1; val1 0 -> SEC_TENS_LIMIT borrows from val2; val2 0 -> 9 borrows from val3. val3 never underflows because 00:00 is terminal.
  - A decrement from 00:01 lands on 00:00 and enters DONE on the same edge.
  - start_pause -> PAUSE; a decrease in the same cycle is dropped.
- PAUSE:
  - Value holds and decrease is ignored.
  - start_pause -> RUN; a decrease in the same cycle is dropped.
- DONE:
  - Value holds at 00:00 and done=1.
  - done_pulse=1 only in the first cycle of DONE.
  - decrease and start_pause are ignored; only load or reset leaves DONE.
- running=1 exactly when in RUN. Digits never take illegal BCD values.
- Latency: one clock from the qualifying input edge to the updated outputs.

Test Plan:
- Reset mid-run: load 05:30, start, 3 decreases, assert rst_n=0 -> val3..val0=0000, running=0, done=0 immediately (asynchronous, not at the next edge).
- Simple decrement: load 01:30, start_pause, 1 decrease -> 01:29; 30 more decreases -> 00:59, confirming the minute borrow.
- Full borrow chain: load 10:00, start, 1 decrease -> 09:59, single-cycle update, no illegal intermediate digit.
- Terminal: load 00:02, start, 2 decreases -> 00:00, done=1, done_pulse high exactly 1 cycle, running=0; 5 further decreases plus start_pause -> still 00:00 in DONE; load 00:10 -> IDLE with 00:10.
- Pause/simultaneity: running at 02:00, start_pause and decrease in the same cycle -> PAUSE at 02:00; 4 decreases -> no change; start_pause -> RUN; 1 decrease -> 01:59. load asserted with start_pause -> IDLE with loaded value.
- Clamp and zero start: load_val3..0 = 7,9,8,A -> 59:59 loaded; load 00:00 then start_pause -> stays IDLE, running=0.

Source files
------------

// File: rtl/downcounter_mmss_timer.sv
// Four-digit BCD MM:SS countdown timer with a borrow chain.
// Loaded from switches, ticked at 1 Hz, and reports completion as a level and a pulse.
module downcounter_mmss_timer #(
    parameter int BCD_BIT_WIDTH  = 4,
    parameter int SEC_TENS_LIMIT = 5,
    parameter int MIN_TENS_LIMIT = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     decrease,
    input  logic                     start_pause,
    input  logic                     load,
    input  logic [BCD_BIT_WIDTH-1:0] load_val0,
    input  logic [BCD_BIT_WIDTH-1:0] load_val1,
    input  logic [BCD_BIT_WIDTH-1:0] load_val2,
    input  logic [BCD_BIT_WIDTH-1:0] load_val3,
    output logic [BCD_BIT_WIDTH-1:0] val0,
    output logic [BCD_BIT_WIDTH-1:0] val1,
    output logic [BCD_BIT_WIDTH-1:0] val2,
    output logic [BCD_BIT_WIDTH-1:0] val3,
    output logic                     running,
    output logic                     done,
    output logic                     done_pulse
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [BCD_BIT_WIDTH-1:0] NINE     = BCD_BIT_WIDTH'(9);
    localparam logic [BCD_BIT_WIDTH-1:0] ONE      = BCD_BIT_WIDTH'(1);
    localparam logic [BCD_BIT_WIDTH-1:0] SEC_TMAX = BCD_BIT_WIDTH'(SEC_TENS_LIMIT);
    localparam logic [BCD_BIT_WIDTH-1:0] MIN_TMAX = BCD_BIT_WIDTH'(MIN_TENS_LIMIT);

    state_t                   state, state_nx;
    logic [BCD_BIT_WIDTH-1:0] v0_nx, v1_nx, v2_nx, v3_nx;
    logic                     running_nx, done_nx, done_pulse_nx;
    logic                     is_zero, is_one;

    assign is_zero = (val3 == '0) && (val2 == '0) && (val1 == '0) && (val0 == '0);
    assign is_one  = (val3 == '0) && (val2 == '0) && (val1 == '0) && (val0 == ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            val0       <= '0;
            val1       <= '0;
            val2       <= '0;
            val3       <= '0;
            running    <= 1'b0;
            done       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            val0       <= v0_nx;
            val1       <= v1_nx;
            val2       <= v2_nx;
            val3       <= v3_nx;
            running    <= running_nx;
            done       <= done_nx;
            done_pulse <= done_pulse_nx;
        end
    end

    // Priority is load > start_pause > decrease in every state.
    always_comb begin
        state_nx = state;
        v0_nx    = val0;
        v1_nx    = val1;
        v2_nx    = val2;
        v3_nx    = val3;
        if (load) begin
            state_nx = IDLE;
            v0_nx    = (load_val0 > NINE)     ? NINE     : load_val0;
            v1_nx    = (load_val1 > SEC_TMAX) ? SEC_TMAX : load_val1;
            v2_nx    = (load_val2 > NINE)     ? NINE     : load_val2;
            v3_nx    = (load_val3 > MIN_TMAX) ? MIN_TMAX : load_val3;
        end else begin
            case (state)
                IDLE:  if (start_pause && !is_zero) state_nx = RUN;
                RUN: begin
                    if (start_pause) begin
                        state_nx = PAUSE;
                    end else if (decrease) begin
                        if (is_one) state_nx = DONE;
                        if (val0 != '0) begin
                            v0_nx = val0 - ONE;
                        end else begin
                            v0_nx = NINE;
                            if (val1 != '0) begin
                                v1_nx = val1 - ONE;
                            end else begin
                                v1_nx = SEC_TMAX;
                                if (val2 != '0) begin
                                    v2_nx = val2 - ONE;
                                end else begin
                                    v2_nx = NINE;
                                    v3_nx = val3 - ONE;
                                end
                            end
                        end
                    end
                end
                PAUSE: if (start_pause) state_nx = RUN;
                DONE:  state_nx = DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        running_nx    = (state_nx == RUN);
        done_nx       = (state_nx == DONE);
        done_pulse_nx = (state_nx == DONE) && (state != DONE);
    end

endmodule

// File: tb/tb_downcounter_mmss_timer.sv
// Directed, table-driven bench for the MM:SS countdown timer.
// Each record drives one cycle of inputs and states the expected outputs after the edge.
module tb_downcounter_mmss_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       decrease = 1'b0;
    logic       start_pause = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val0 = '0, load_val1 = '0, load_val2 = '0, load_val3 = '0;
    logic [3:0] val0, val1, val2, val3;
    logic       running, done, done_pulse;

    int tests = 0;
    int fails = 0;

    downcounter_mmss_timer #(
        .BCD_BIT_WIDTH (4),
        .SEC_TENS_LIMIT(5),
        .MIN_TENS_LIMIT(5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .decrease   (decrease),
        .start_pause(start_pause),
        .load       (load),
        .load_val0  (load_val0),
        .load_val1  (load_val1),
        .load_val2  (load_val2),
        .load_val3  (load_val3),
        .val0       (val0),
        .val1       (val1),
        .val2       (val2),
        .val3       (val3),
        .running    (running),
        .done       (done),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        sp;
        logic        dec;
        logic [15:0] lv;   // {load_val3, load_val2, load_val1, load_val0}
        logic [15:0] ev;   // expected {val3, val2, val1, val0}
        logic        er;
        logic        ed;
        logic        ep;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] ev,
                         input logic er, input logic ed, input logic ep);
        logic [18:0] act, exp;
        act = {val3, val2, val1, val0, running, done, done_pulse};
        exp = {ev, er, ed, ep};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h run=%b done=%b pulse=%b, expected %h run=%b done=%b pulse=%b",
                     name, act[18:3], act[2], act[1], act[0], ev, er, ed, ep);
        end
    endtask

    task automatic cycle(input logic ld, input logic sp, input logic dec, input logic [15:0] lv);
        load = ld;
        start_pause = sp;
        decrease = dec;
        {load_val3, load_val2, load_val1, load_val0} = lv;
        @(posedge clk);
        #1;
        load = 1'b0;
        start_pause = 1'b0;
        decrease = 1'b0;
    endtask

    task automatic add(input logic ld, input logic sp, input logic dec, input logic [15:0] lv,
                       input logic [15:0] ev, input logic er, input logic ed, input logic ep);
        vec_t v;
        v.ld = ld; v.sp = sp; v.dec = dec; v.lv = lv;
        v.ev = ev; v.er = er; v.ed = ed; v.ep = ep;
        vecs.push_back(v);
    endtask

    initial begin
        // ld sp dec  load_val   expected  run done pulse
        add(1, 0, 0, 16'h1000, 16'h1000, 0, 0, 0);
        add(0, 1, 0, 16'h0000, 16'h1000, 1, 0, 0);
        add(0, 0, 1, 16'h0000, 16'h0959, 1, 0, 0);   // full borrow chain
        add(1, 0, 0, 16'h0002, 16'h0002, 0, 0, 0);
        add(0, 1, 0, 16'h0000, 16'h0002, 1, 0, 0);
        add(0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0);
        add(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1);   // enters DONE
        add(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0);
        add(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0);
        add(0, 1, 0, 16'h0000, 16'h0000, 0, 1, 0);
        add(1, 0, 0, 16'h0010, 16'h0010, 0, 0, 0);
        add(1, 0, 0, 16'h0200, 16'h0200, 0, 0, 0);
        add(0, 1, 0, 16'h0000, 16'h0200, 1, 0, 0);
        add(0, 1, 1, 16'h0000, 16'h0200, 0, 0, 0);   // pause wins, decrease dropped
        add(0, 0, 1, 16'h0000, 16'h0200, 0, 0, 0);
        add(0, 0, 1, 16'h0000, 16'h0200, 0, 0, 0);
        add(0, 0, 1, 16'h0000, 16'h0200, 0, 0, 0);
        add(0, 0, 1, 16'h0000, 16'h0200, 0, 0, 0);
        add(0, 1, 1, 16'h0000, 16'h0200, 1, 0, 0);   // resume, decrease dropped
        add(0, 0, 1, 16'h0000, 16'h0159, 1, 0, 0);
        add(1, 1, 1, 16'h0345, 16'h0345, 0, 0, 0);   // load beats start_pause
        add(0, 0, 1, 16'h0000, 16'h0345, 0, 0, 0);   // IDLE ignores decrease
        add(1, 0, 0, 16'h798A, 16'h5959, 0, 0, 0);   // clamp
        add(0, 1, 0, 16'h0000, 16'h5959, 1, 0, 0);
        add(0, 0, 1, 16'h0000, 16'h5958, 1, 0, 0);
        add(0, 1, 0, 16'h0000, 16'h5958, 0, 0, 0);
        add(1, 0, 0, 16'h0123, 16'h0123, 0, 0, 0);   // load from PAUSE
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);   // zero start ignored
        add(1, 0, 0, 16'h0001, 16'h0001, 0, 0, 0);
        add(0, 1, 0, 16'h0000, 16'h0001, 1, 0, 0);
        add(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1);
        add(1, 0, 1, 16'h0005, 16'h0005, 0, 0, 0);   // load leaves DONE

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 16'h0000, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            cycle(vecs[i].ld, vecs[i].sp, vecs[i].dec, vecs[i].lv);
            check($sformatf("vec[%0d]", i), vecs[i].ev, vecs[i].er, vecs[i].ed, vecs[i].ep);
        end

        // Simple decrement with minute borrow
        cycle(1, 0, 0, 16'h0130);
        cycle(0, 1, 0, 16'h0000);
        cycle(0, 0, 1, 16'h0000);
        check("dec_0129", 16'h0129, 1, 0, 0);
        for (int i = 0; i < 29; i++) cycle(0, 0, 1, 16'h0000);
        check("dec_0100", 16'h0100, 1, 0, 0);
        cycle(0, 0, 1, 16'h0000);
        check("dec_0059", 16'h0059, 1, 0, 0);

        // Asynchronous reset mid-run
        cycle(1, 0, 0, 16'h0530);
        cycle(0, 1, 0, 16'h0000);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 16'h0000);
        check("run_0527", 16'h0527, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 16'h0000, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset", 16'h0000, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
